// File: rtl/ras.sv
// Return address stack for the fetch stage: a speculative stack driven by
// BTB call/return predictions, restored on flush from a commit-time stack.
package ras_pkg;
    typedef enum logic [1:0] {
        BRTYPE_NONE = 2'd0,
        BRTYPE_JUMP = 2'd1,
        BRTYPE_CALL = 2'd2,
        BRTYPE_RET  = 2'd3
    } BrInstType_t;
endpackage

module ras
    import ras_pkg::*;
#(
    parameter int ADDR       = 32,
    parameter int RAS_D      = 8,
    parameter int INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pred_valid,
    input  logic [ADDR-1:0]   pc,
    input  logic              btb_hit,
    input  BrInstType_t       btb_type,
    output logic              ras_hit,
    output logic [ADDR-1:0]   ras_addr,
    input  logic              jump_commit_,
    input  logic              jump_call_,
    input  logic              jump_return_,
    input  logic [ADDR-1:0]   com_pc,
    input  logic              flush_,
    output logic              ras_empty
);

    localparam int PW = $clog2(RAS_D);
    localparam logic [ADDR-1:0] IB = ADDR'(INST_BYTES);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_D);

    logic [ADDR-1:0] spec_buf_q [RAS_D];
    logic [ADDR-1:0] spec_buf_d [RAS_D];
    logic [PW-1:0]   spec_sp_q, spec_sp_d;
    logic [PW:0]     spec_cnt_q, spec_cnt_d;

    logic [ADDR-1:0] com_buf_q [RAS_D];
    logic [ADDR-1:0] com_buf_d [RAS_D];
    logic [PW-1:0]   com_sp_q, com_sp_d;
    logic [PW:0]     com_cnt_q, com_cnt_d;

    logic [ADDR-1:0] com_ret;
    logic [ADDR-1:0] spec_ret;

    assign com_ret  = com_pc + IB;
    assign spec_ret = pc + IB;

    assign ras_addr  = spec_buf_q[spec_sp_q - 1'b1];
    assign ras_empty = (spec_cnt_q == '0);
    assign ras_hit   = pred_valid & btb_hit
                     & (btb_type == BRTYPE_RET) & ~ras_empty;

    // Commit stack next state from the architectural jump history.
    always_comb begin
        com_buf_d = com_buf_q;
        com_sp_d  = com_sp_q;
        com_cnt_d = com_cnt_q;
        if (!jump_commit_) begin
            unique case ({jump_return_, jump_call_})
                2'b10: begin
                    com_buf_d[com_sp_q] = com_ret;
                    com_sp_d = com_sp_q + 1'b1;
                    if (com_cnt_q != FULL) com_cnt_d = com_cnt_q + 1'b1;
                end
                2'b01: begin
                    if (com_cnt_q != '0) begin
                        com_sp_d  = com_sp_q - 1'b1;
                        com_cnt_d = com_cnt_q - 1'b1;
                    end
                end
                2'b00: begin
                    if (com_cnt_q == '0) begin
                        com_buf_d[com_sp_q] = com_ret;
                        com_sp_d  = com_sp_q + 1'b1;
                        com_cnt_d = com_cnt_q + 1'b1;
                    end else begin
                        com_buf_d[com_sp_q - 1'b1] = com_ret;
                    end
                end
                default: ;
            endcase
        end
    end

    // Speculative stack next state: flush restores from commit, else predict.
    always_comb begin
        spec_buf_d = spec_buf_q;
        spec_sp_d  = spec_sp_q;
        spec_cnt_d = spec_cnt_q;
        if (!flush_) begin
            spec_buf_d = com_buf_d;
            spec_sp_d  = com_sp_d;
            spec_cnt_d = com_cnt_d;
        end else if (pred_valid && btb_hit) begin
            if (btb_type == BRTYPE_CALL) begin
                spec_buf_d[spec_sp_q] = spec_ret;
                spec_sp_d = spec_sp_q + 1'b1;
                if (spec_cnt_q != FULL) spec_cnt_d = spec_cnt_q + 1'b1;
            end else if (btb_type == BRTYPE_RET && spec_cnt_q != '0) begin
                spec_sp_d  = spec_sp_q - 1'b1;
                spec_cnt_d = spec_cnt_q - 1'b1;
            end
        end
    end

    // Register both stacks; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_D; i++) begin
                spec_buf_q[i] <= '0;
                com_buf_q[i]  <= '0;
            end
            spec_sp_q  <= '0;
            spec_cnt_q <= '0;
            com_sp_q   <= '0;
            com_cnt_q  <= '0;
        end else begin
            spec_buf_q <= spec_buf_d;
            spec_sp_q  <= spec_sp_d;
            spec_cnt_q <= spec_cnt_d;
            com_buf_q  <= com_buf_d;
            com_sp_q   <= com_sp_d;
            com_cnt_q  <= com_cnt_d;
        end
    end

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: directed scenarios plus random traffic
// compared against a queue-based model of both stacks.
module tb_ras;
    import ras_pkg::*;

    localparam int RAS_D = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        pred_valid;
    logic [31:0] pc;
    logic        btb_hit;
    BrInstType_t btb_type;
    logic        ras_hit;
    logic [31:0] ras_addr;
    logic        jump_commit_;
    logic        jump_call_;
    logic        jump_return_;
    logic [31:0] com_pc;
    logic        flush_;
    logic        ras_empty;

    int passes = 0;
    int total  = 0;

    logic [31:0] mspec[$];
    logic [31:0] mcom[$];

    ras #(.ADDR(32), .RAS_D(RAS_D), .INST_BYTES(4)) dut (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pc(pc),
        .btb_hit(btb_hit), .btb_type(btb_type), .ras_hit(ras_hit),
        .ras_addr(ras_addr), .jump_commit_(jump_commit_),
        .jump_call_(jump_call_), .jump_return_(jump_return_),
        .com_pc(com_pc), .flush_(flush_), .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic void qpush(ref logic [31:0] q[$], input logic [31:0] v);
        q.push_back(v);
        if (q.size() > RAS_D) void'(q.pop_front());
    endfunction

    // Compare outputs with the model, take one edge, advance the model.
    task automatic cyc(input logic pv, input logic [31:0] p, input logic h,
                       input BrInstType_t t, input logic jc, input logic jcl,
                       input logic jr, input logic [31:0] cp, input logic fl,
                       input string tag);
        logic [31:0] cn[$];
        logic        exp_hit;
        pred_valid = pv; pc = p; btb_hit = h; btb_type = t;
        jump_commit_ = jc; jump_call_ = jcl; jump_return_ = jr;
        com_pc = cp; flush_ = fl;
        #1;
        exp_hit = pv && h && t == BRTYPE_RET && mspec.size() != 0;
        chk({tag, ".hit"}, 32'(ras_hit), 32'(exp_hit));
        chk({tag, ".empty"}, 32'(ras_empty), 32'(mspec.size() == 0));
        if (mspec.size() != 0) chk({tag, ".addr"}, ras_addr, mspec[$]);
        @(posedge clk);
        cn = mcom;
        if (!jc) begin
            case ({jr, jcl})
                2'b10: qpush(cn, cp + 4);
                2'b01: if (cn.size() != 0) void'(cn.pop_back());
                2'b00: if (cn.size() == 0) qpush(cn, cp + 4);
                       else cn[cn.size()-1] = cp + 4;
                default: ;
            endcase
        end
        if (!fl) mspec = cn;
        else if (pv && h) begin
            if (t == BRTYPE_CALL) qpush(mspec, p + 4);
            else if (t == BRTYPE_RET && mspec.size() != 0)
                void'(mspec.pop_back());
        end
        mcom = cn;
        @(negedge clk);
    endtask

    task automatic pcall(input logic [31:0] p, input string tag);
        cyc(1, p, 1, BRTYPE_CALL, 1, 1, 1, 0, 1, tag);
    endtask

    task automatic pret(input logic [31:0] p, input string tag);
        cyc(1, p, 1, BRTYPE_RET, 1, 1, 1, 0, 1, tag);
    endtask

    task automatic idle(input string tag);
        cyc(0, 0, 0, BRTYPE_NONE, 1, 1, 1, 0, 1, tag);
    endtask

    initial begin
        reset = 1'b1;
        pred_valid = 1; pc = 32'h200; btb_hit = 1; btb_type = BRTYPE_RET;
        jump_commit_ = 1; jump_call_ = 1; jump_return_ = 1;
        com_pc = 0; flush_ = 1;
        #1;
        chk("rst.hit", 32'(ras_hit), 32'h0);
        chk("rst.addr", ras_addr, 32'h0);
        chk("rst.empty", 32'(ras_empty), 32'h1);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Basic call then return.
        pcall(32'h100, "call1");
        chk("call1.top", ras_addr, 32'h104);
        chk("call1.nempty", 32'(ras_empty), 32'h0);
        pret(32'h200, "ret1");
        chk("ret1.empty", 32'(ras_empty), 32'h1);

        // Underflow: return on an empty stack is ignored.
        pret(32'h200, "uflow");
        chk("uflow.empty", 32'(ras_empty), 32'h1);

        // Overflow: nine calls, eight returns.
        for (int k = 0; k < 9; k++) pcall(32'h1000 + 32'h10 * k, "ovf.call");
        for (int k = 8; k >= 1; k--) begin
            chk("ovf.order", ras_addr, 32'h1004 + 32'h10 * k);
            pret(32'h2000, "ovf.ret");
        end
        chk("ovf.empty", 32'(ras_empty), 32'h1);

        // Flush restores the commit stack including same-cycle commit.
        pcall(32'h100, "fl.c1");
        pcall(32'h200, "fl.c2");
        cyc(0, 0, 0, BRTYPE_NONE, 0, 0, 1, 32'h100, 0, "fl.flush");
        chk("fl.top", ras_addr, 32'h104);
        pcall(32'h500, "fl.c3");
        pret(32'h600, "fl.r1");
        pret(32'h600, "fl.r2");
        chk("fl.cnt1", 32'(ras_empty), 32'h1);

        // Coroutine commit with flush replaces the top.
        cyc(0, 0, 0, BRTYPE_NONE, 0, 0, 0, 32'h300, 0, "co.flush");
        chk("co.top", ras_addr, 32'h304);
        pret(32'h600, "co.r1");
        chk("co.cnt", 32'(ras_empty), 32'h1);

        // Randomised traffic on both stacks.
        for (int n = 0; n < 400; n++) begin
            logic [2:0] ck;
            ck = 3'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 7) != 0),
                32'($urandom) & 32'hffff_fffc,
                1'($urandom_range(0, 3) != 0),
                BrInstType_t'($urandom_range(0, 3)),
                ck[0], ck[1], ck[2],
                32'($urandom) & 32'hffff_fffc,
                1'($urandom_range(0, 15) != 0), "rnd");
        end

        // Mid-cycle asynchronous reset with non-empty stacks.
        pcall(32'h700, "ar.c1");
        pcall(32'h800, "ar.c2");
        pred_valid = 1; btb_hit = 1; btb_type = BRTYPE_RET;
        #2;
        reset = 1'b1;
        #1;
        chk("ar.hit", 32'(ras_hit), 32'h0);
        chk("ar.addr", ras_addr, 32'h0);
        chk("ar.empty", 32'(ras_empty), 32'h1);
        mspec.delete();
        mcom.delete();
        @(negedge clk);
        reset = 1'b0;
        pcall(32'h900, "ar.c3");
        chk("ar.top", ras_addr, 32'h904);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ras.md
Name: ras

Overview:
- Return address stack sitting directly downstream of the BTB in the fetch stage.
- Consumes the BTB's hit/type classification of the current fetch PC.
  - Pushes return addresses on predicted calls.
  - Supplies the predicted target on predicted returns.
- A second, commit-time stack tracks architectural call/return history from the same commit bus that trains the BTB.
- On a pipeline flush, the speculative stack is restored from the commit stack.

Parameters:
- ADDR, `AddrWidth, address width.
- RAS_D, 8, stack depth in entries; power of two, ≥2.
- INST_BYTES, `InstWidth/`ByteBitWidth, return-address offset added to a call PC.

Ports:
- clk  input  1  clock; one clock domain.
- reset  input  1  reset; asynchronous, active-high.
- pred_valid  input  1  fetch PC valid this cycle (not stalled); active-high.
- pc  input  ADDR  fetch PC, same value presented to the BTB.
- btb_hit  input  1  BTB target valid for pc.
- btb_type  input  BrInstType_t  BTB instruction type for pc.
- ras_hit  output  1  return predicted and stack non-empty; use ras_addr as target.
- ras_addr  output  ADDR  top of speculative stack.
- jump_commit_  input  1  jump commit, active-low.
- jump_call_  input  1  committed jump is call, active-low.
- jump_return_  input  1  committed jump is return, active-low.
- com_pc  input  ADDR  commit PC.
- flush_  input  1  pipeline flush / mispredict recovery, active-low.
- ras_empty  output  1  speculative stack count is zero.

Behaviour:
- State: two stacks, speculative (spec) and commit (com). Each has:
  - buf[RAS_D] of ADDR bits
  - sp: log2(RAS_D) bits, index of next free slot
  - cnt: log2(RAS_D)+1 bits, valid entries 0..RAS_D.
- Reset (async, active-high): all buf, sp and cnt cleared to 0. Outputs: ras_hit=0, ras_addr=0, ras_empty=1.
- Outputs (combinational from registered state, zero added latency):
  - ras_addr = spec.buf[spec.sp-1], index wraps modulo RAS_D.
  - ras_empty = (spec.cnt==0).
  - ras_hit = pred_valid & btb_hit & (btb_type==BRTYPE_RET) & !ras_empty.
- Speculative update, posedge, only when flush_ is high and pred_valid & btb_hit:
  - BRTYPE_CALL: buf[sp] <= pc+INST_BYTES (modulo 2^ADDR); sp <= sp+1 (wrap); cnt <= min(cnt+1, RAS_D).
  - BRTYPE_RET: if cnt>0, sp <= sp-1 (wrap) and cnt <= cnt-1. If cnt==0, no change.
  - Other types: no change.
  - A pushed value is visible on ras_addr the next cycle.
- Overflow: a push when cnt==RAS_D overwrites the oldest entry; cnt stays at RAS_D. A subsequent RAS_D pops return the newest RAS_D addresses, after which the stack is empty.
- Underflow: a pop at cnt==0 is ignored and ras_hit=0. Fetch then falls back to btb_addr.
- Commit update, posedge, when jump_commit_==0, selected by {jump_return_, jump_call_}:
  - {1,0} call: push com_pc+INST_BYTES.
  - {0,1} return: pop (ignored if cnt==0).
  - {0,0} return+call (coroutine): replace top: buf[sp-1] <= com_pc+INST_BYTES, sp and cnt unchanged. If cnt==0, behaves as a push.
  - {1,1} plain jump: no change.
  - Same overflow/underflow rules as spec.
- Flush (flush_==0 at posedge):
  - The spec stack (buf, sp, cnt) loads the commit stack's next state, i.e. including any same-cycle commit update.
  - The speculative update for that cycle is discarded.
  - The commit stack is never affected by flush.
- Simultaneous speculative and commit updates in a non-flush cycle are independent.
- Reset asserted mid-operation clears both stacks immediately, regardless of clk.

Test Plan:
- Reset, then pred_valid=1, btb_hit=1, CALL at pc=0x100 → next cycle ras_addr=0x104, ras_empty=0. Then RET at pc=0x200 → ras_hit=1, ras_addr=0x104; following cycle ras_empty=1.
- RET with empty stack (btb_hit=1, RET) → ras_hit=0, state unchanged, ras_empty stays 1.
- RAS_D+1=9 CALLs at pc=0x1000+0x10*k → cnt saturates at 8. Successive RET ras_addr = 0x1084, 0x1074, … down to 0x1014; then ras_empty=1. The 0x1004 entry is lost.
- Spec CALLs at 0x100 and 0x200; commit call com_pc=0x100; flush_=0 → next cycle ras_addr=0x104 with cnt=1.
- Commit coroutine ({0,0}) com_pc=0x300 on a stack topped by 0x104, plus flush in the same cycle → spec top=0x304, cnt unchanged.
- Assert reset while stacks are non-empty, between clock edges → outputs go to ras_hit=0, ras_addr=0, ras_empty=1 without waiting for clk.
